// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants used by fetch and decode.
package riscv_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Major opcodes, consumed by decode and the immediate generator.
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem request, one-entry IF/ID register toward
// decode, and redirect handling that flushes and drops in-flight responses.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4
);

   fetch_state_t    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] req_pc_q;
   logic            id_valid_q;
   logic [XLEN-1:0] id_instr_q;
   logic [XLEN-1:0] id_pc_q;
   logic [XLEN-1:0] id_pc_plus4_q;

   logic            slot_free;
   logic            req_fire;
   logic            capture;
   logic [XLEN-1:0] redirect_tgt;

   // Issuing only when the slot is free guarantees room for the response.
   assign slot_free      = !id_valid_q || id_ready;
   assign imem_req_valid = (state_q == REQ) && slot_free && !redirect_valid;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign capture        = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
   assign redirect_tgt   = redirect_pc & ~XLEN'(3);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= REQ;
         pc_q          <= RESET_PC;
         req_pc_q      <= RESET_PC;
         id_valid_q    <= 1'b0;
         id_instr_q    <= NOP_INSTR;
         id_pc_q       <= RESET_PC;
         id_pc_plus4_q <= RESET_PC + XLEN'(4);
      end else if (redirect_valid) begin
         pc_q       <= redirect_tgt;
         id_valid_q <= 1'b0;
         case (state_q)
            REQ:     state_q <= REQ;
            WAIT:    state_q <= imem_rsp_valid ? REQ : DROP;
            DROP:    state_q <= imem_rsp_valid ? REQ : DROP;
            default: state_q <= REQ;
         endcase
      end else begin
         if (id_valid_q && id_ready) begin
            id_valid_q <= 1'b0;
         end
         case (state_q)
            REQ: begin
               if (req_fire) begin
                  req_pc_q <= pc_q;
                  pc_q     <= pc_q + XLEN'(4);
                  state_q  <= WAIT;
               end
            end
            WAIT: begin
               if (capture) begin
                  id_instr_q    <= imem_rsp_data;
                  id_pc_q       <= req_pc_q;
                  id_pc_plus4_q <= req_pc_q + XLEN'(4);
                  id_valid_q    <= 1'b1;
                  state_q       <= REQ;
               end
            end
            DROP: begin
               if (imem_rsp_valid) begin
                  state_q <= REQ;
               end
            end
            default: state_q <= REQ;
         endcase
      end
   end

   assign id_valid    = id_valid_q;
   assign id_instr    = id_instr_q;
   assign id_pc       = id_pc_q;
   assign id_pc_plus4 = id_pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small latency-programmable imem model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;

   int n_cmp  = 0;
   int n_fail = 0;
   int mem_lat = 1;

   instr_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   // Memory: accept sampled at the edge, response mem_lat cycles later.
   initial begin
      logic        fire;
      logic [31:0] a;
      logic [31:0] pend;
      int          cnt;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      cnt  = 0;
      pend = 32'h0;
      forever begin
         @(posedge clk);
         fire = imem_req_valid && imem_req_ready && !rst;
         a    = imem_req_addr;
         #1;
         imem_rsp_valid = 1'b0;
         if (rst) cnt = 0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(pend);
            end
         end
         if (fire) begin
            pend = a;
            if (mem_lat == 1) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(a);
            end else begin
               cnt = mem_lat - 1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   // Leaves rst deasserted at a falling edge (cycle N0), nothing sampled yet.
   task automatic do_reset(input logic rdy, input logic idr);
      @(negedge clk);
      rst = 1'b1; imem_req_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 32'h0; id_ready = idr; mem_lat = 1;
      cyc(); cyc();
      rst = 1'b0; imem_req_ready = rdy;
   endtask

   task automatic test_reset();
      do_reset(1'b1, 1'b1);
      #1;
      n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got %h want 0", id_valid); end
      n_cmp++; if (id_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_id_instr got %h want 00000013", id_instr); end
      n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
      n_cmp++; if (id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_id_pc_plus4 got %h want 4", id_pc_plus4); end
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_first_req got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
      // Mid-operation reset while a response is in flight.
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0; imem_req_ready = 1'b0;
      #1;
      n_cmp++; if (id_valid !== 1'b0 || id_pc !== 32'h0) begin n_fail++; $display("FAIL midreset_outputs got v=%b pc=%h want v=0 pc=0", id_valid, id_pc); end
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL midreset_req got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] epc;
      do_reset(1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         epc = 32'(4 * k);
         cyc(); #1;
         n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_gap%0d got %b want 0", k, id_valid); end
         cyc(); #1;
         n_cmp++; if (id_valid !== 1'b1 || id_pc !== epc) begin n_fail++; $display("FAIL stream_pc%0d got v=%b pc=%h want v=1 pc=%h", k, id_valid, id_pc, epc); end
         n_cmp++; if (id_instr !== mem_word(epc)) begin n_fail++; $display("FAIL stream_instr%0d got %h want %h", k, id_instr, mem_word(epc)); end
         n_cmp++; if (id_pc_plus4 !== epc + 32'd4) begin n_fail++; $display("FAIL stream_plus4_%0d got %h want %h", k, id_pc_plus4, epc + 32'd4); end
      end
   endtask

   task automatic test_backpressure();
      do_reset(1'b1, 1'b0);
      cyc();
      for (int i = 0; i < 5; i++) begin
         cyc(); #1;
         n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL bp_hold%0d got v=%b pc=%h i=%h want v=1 pc=0 i=%h", i, id_valid, id_pc, id_instr, mem_word(32'h0)); end
         n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_noreq%0d got %b want 0", i, imem_req_valid); end
      end
      cyc();
      id_ready = 1'b1;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL bp_release_req got v=%b a=%h want v=1 a=4", imem_req_valid, imem_req_addr); end
      cyc(); #1;
      n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", id_valid); end
      cyc(); #1;
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h4) begin n_fail++; $display("FAIL bp_next got v=%b pc=%h want v=1 pc=4", id_valid, id_pc); end
   endtask

   task automatic test_redirect_wait();
      do_reset(1'b1, 1'b1);
      mem_lat = 3;
      cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
      cyc();
      redirect_valid = 1'b0;
      #1;
      n_cmp++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rw_flush got v=%b req=%b want v=0 req=0", id_valid, imem_req_valid); end
      cyc(); #1;
      n_cmp++; if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rw_late_rsp got rsp=%b req=%b want rsp=1 req=0", imem_rsp_valid, imem_req_valid); end
      cyc();
      mem_lat = 1;
      #1;
      n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rw_dropped got %b want 0", id_valid); end
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rw_target got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
      cyc(); cyc(); #1;
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL rw_capture got v=%b pc=%h i=%h want v=1 pc=100 i=%h", id_valid, id_pc, id_instr, mem_word(32'h100)); end
   endtask

   task automatic test_redirect_same_rsp();
      do_reset(1'b1, 1'b1);
      cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      #1;
      n_cmp++; if (imem_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rs_rsp_present got %b want 1", imem_rsp_valid); end
      cyc();
      redirect_valid = 1'b0;
      #1;
      n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rs_discard got %b want 0", id_valid); end
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL rs_target got v=%b a=%h want v=1 a=00000200", imem_req_valid, imem_req_addr); end
      cyc(); cyc(); #1;
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin n_fail++; $display("FAIL rs_capture got v=%b pc=%h want v=1 pc=200", id_valid, id_pc); end
   endtask

   task automatic test_req_stall();
      do_reset(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL stall_hold%0d got v=%b a=%h want v=1 a=0", i, imem_req_valid, imem_req_addr); end
         cyc();
      end
      imem_req_ready = 1'b1;
      #1;
      n_cmp++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL stall_accept_addr got %h want 0", imem_req_addr); end
      cyc(); cyc(); #1;
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL stall_after got v=%b pc=%h a=%h want v=1 pc=0 a=4", id_valid, id_pc, imem_req_addr); end
   endtask

   task automatic test_wrap();
      do_reset(1'b1, 1'b1);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_suppress got %b want 0", imem_req_valid); end
      cyc();
      redirect_valid = 1'b0;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req got v=%b a=%h want v=1 a=fffffffc", imem_req_valid, imem_req_addr); end
      cyc(); cyc(); #1;
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_first got v=%b pc=%h p4=%h want v=1 pc=fffffffc p4=0", id_valid, id_pc, id_pc_plus4); end
      n_cmp++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr got %h want 0", imem_req_addr); end
      cyc(); cyc(); #1;
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL wrap_second got v=%b pc=%h p4=%h want v=1 pc=0 p4=4", id_valid, id_pc, id_pc_plus4); end
   endtask

   initial begin
      rst = 1'b1; imem_req_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 32'h0; id_ready = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_same_rsp();
      test_req_stall();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of decode.
- Holds the PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Captures each returned word into a one-entry IF/ID output register that decode consumes with valid/ready. Decode is where the immediate generator sits.
- Accepts a redirect (branch/jump target) from execute, flushing fetched work and dropping any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, address and instruction width; only 32 supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  XLEN  word-aligned fetch address.
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  XLEN  fetched instruction.
- redirect_valid  input  1  execute requests PC change, 1-cycle pulse.
- redirect_pc  input  XLEN  new PC; bits [1:0] ignored, forced 0.
- id_valid  output  1  IF/ID register holds an instruction.
- id_ready  input  1  decode accepts this cycle.
- id_instr  output  XLEN  instruction to decode.
- id_pc  output  XLEN  PC of id_instr.
- id_pc_plus4  output  XLEN  id_pc + 4, mod 2^32.

Behaviour:
- Reset (rst=1 at edge) sets:
  - pc_q = RESET_PC, state = REQ, id_valid = 0.
  - id_instr = 32'h0000_0013 (NOP).
  - id_pc = RESET_PC, id_pc_plus4 = RESET_PC+4.
  - Reset mid-operation abandons any outstanding request.
- slot_free = !id_valid || id_ready. Output slot is empty or draining this cycle.
- imem_req_valid = (state==REQ) && slot_free && !redirect_valid. imem_req_addr = pc_q; combinational.
- Requests:
  - At most one outstanding request.
  - Because issue requires slot_free, the slot is guaranteed free when the response returns.
- REQ:
  - On imem_req_valid && imem_req_ready: req_pc_q <= pc_q, pc_q <= pc_q+4 (wraps 0xFFFF_FFFC -> 0), go WAIT.
- WAIT:
  - On imem_rsp_valid: id_instr <= imem_rsp_data, id_pc <= req_pc_q, id_pc_plus4 <= req_pc_q+4, id_valid <= 1, go REQ.
  - Otherwise stay.
- DROP:
  - On imem_rsp_valid: discard the data, go REQ. Otherwise stay.
- Output drain:
  - id_valid && id_ready with no new capture that cycle -> id_valid <= 0.
  - Outputs are held stable while id_valid && !id_ready.
- Redirect (redirect_valid=1) has highest priority over every other update that cycle:
  - pc_q <= {redirect_pc[31:2],2'b00}, id_valid <= 0 (flush).
  - From REQ: go REQ. No request was issued, because req_valid is suppressed that cycle.
  - From WAIT without rsp: go DROP. From WAIT with rsp the same cycle: response discarded, go REQ.
  - From DROP: go DROP, or REQ if rsp arrives that cycle.
  - A redirect may withdraw a request that was not yet accepted; the memory must tolerate this.
- imem_rsp_valid in state REQ is ignored. This covers stray responses after reset.
- Timing with a zero-wait memory (ready=1, rsp one cycle after accept):
  - First id_valid appears 2 cycles after the first cycle out of reset.
  - Steady throughput is 1 instruction per 2 cycles.
- No combinational path from id_ready or imem inputs to id_* outputs. All id_* outputs are registered.

Decomposition:
- riscv_pkg holds:
  - typedef enum fetch_state_t {REQ, WAIT, DROP}.
  - localparam NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC.
  - Opcode constants shared with decode/immediate generation.
- Single module; no sub-module. The IF/ID register is too small to split out.

Test Plan:
- Reset then free-running memory returning addr-derived data, id_ready=1 -> id_pc sequence 0,4,8,12; id_instr matches; one valid every 2 cycles; id_pc_plus4 = id_pc+4.
- Backpressure: id_ready=0 for 5 cycles with id_valid=1 -> outputs stable, imem_req_valid=0 throughout; on release the next request issues that cycle.
- Redirect while in WAIT to 0x0000_0102 -> id_valid=0 next cycle; late response for the old PC dropped; next request addr 0x0000_0100.
- Redirect in the same cycle as imem_rsp_valid -> response discarded, no id_valid; next request at redirect target.
- imem_req_ready held 0 for 3 cycles -> imem_req_valid and imem_req_addr stable; pc_q unchanged until accept.
- PC wrap: redirect to 0xFFFF_FFFC -> instructions at 0xFFFF_FFFC then 0x0000_0000; id_pc_plus4 of the first = 0x0000_0000.
